// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 2^ADDR_W x DATA_W register file with two async read ports,
//            one sync write port, optional zero R0, optional write bypass,
//            and a per-register pending scoreboard with a live busy count.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  iss,
    input  logic [ADDR_W-1:0]     ia,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    output logic                  rv1,
    output logic                  rv2,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [c_DEPTH-1:0][DATA_W-1:0] w_mem;
    logic [c_DEPTH-1:0]             r_busy;
    logic [c_DEPTH-1:0]             w_busy_nxt;
    logic [ADDR_W:0]                r_busy_cnt;
    logic [ADDR_W:0]                w_cnt_nxt;
    logic                           w_wr_zero;
    logic                           w_hit1;
    logic                           w_hit2;

    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign w_mem[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        r_q <= '0;
                    else if (we && wa == ADDR_W'(gi))
                        r_q <= wd;
                end
                assign w_mem[gi] = r_q;
            end
        end
    endgenerate

    // Issue is applied after write-back so a same-address pair leaves the
    // register pending: the newly issued producer owns it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we)
            w_busy_nxt[wa] = 1'b0;
        if (iss)
            w_busy_nxt[ia] = 1'b1;
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < c_DEPTH; i++)
            w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    // Bypass is suppressed during reset so reads hold at zero while rst is high.
    assign w_wr_zero = (ZERO_REG != 0) && (wa == '0);
    assign w_hit1    = (BYPASS != 0) && !rst && we && !w_wr_zero && (wa == ra1);
    assign w_hit2    = (BYPASS != 0) && !rst && we && !w_wr_zero && (wa == ra2);

    always_comb begin
        rd1 = w_hit1 ? wd : w_mem[ra1];
        rv1 = w_hit1 || !r_busy[ra1];
        if (ZERO_REG != 0 && ra1 == '0) begin
            rd1 = '0;
            rv1 = 1'b1;
        end
    end

    always_comb begin
        rd2 = w_hit2 ? wd : w_mem[ra2];
        rv2 = w_hit2 || !r_busy[ra2];
        if (ZERO_REG != 0 && ra2 == '0) begin
            rd2 = '0;
            rv2 = 1'b1;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench driving three regfile_sb configurations
//            (default, no bypass, zero R0) against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       rst, we, iss;
    logic [1:0] wa, ia, ra1, ra2;
    logic [7:0] wd;

    logic [7:0] rd1_o [3];
    logic [7:0] rd2_o [3];
    logic       rv1_o [3];
    logic       rv2_o [3];
    logic [3:0] busy_o [3];
    logic [2:0] cnt_o [3];

    int n_checks = 0;
    int n_errors = 0;

    // Configuration table: index 0 default, 1 without bypass, 2 with zero R0.
    int zr [3] = '{0, 0, 1};
    int bp [3] = '{1, 0, 1};

    bit [7:0] m_mem  [3][4];
    bit       m_busy [3][4];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_def (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_o[0]), .rd2(rd2_o[0]), .rv1(rv1_o[0]),
        .rv2(rv2_o[0]), .busy(busy_o[0]), .busy_cnt(cnt_o[0]));

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) u_nobp (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_o[1]), .rd2(rd2_o[1]), .rv1(rv1_o[1]),
        .rv2(rv2_o[1]), .busy(busy_o[1]), .busy_cnt(cnt_o[1]));

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u_zero (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_o[2]), .rd2(rd2_o[2]), .rv1(rv1_o[2]),
        .rv2(rv2_o[2]), .busy(busy_o[2]), .busy_cnt(cnt_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 4; r++) begin
                m_mem[k][r]  = 8'h00;
                m_busy[k][r] = 1'b0;
            end
    endfunction

    function automatic bit fwd(input int k, input logic [1:0] ra);
        return bp[k] != 0 && !rst && we && wa == ra && !(zr[k] != 0 && wa == 2'd0);
    endfunction

    function automatic logic [7:0] exp_rd(input int k, input logic [1:0] ra);
        if (rst || (zr[k] != 0 && ra == 2'd0)) return 8'h00;
        if (fwd(k, ra)) return wd;
        return m_mem[k][ra];
    endfunction

    function automatic logic exp_rv(input int k, input logic [1:0] ra);
        if (zr[k] != 0 && ra == 2'd0) return 1'b1;
        if (fwd(k, ra)) return 1'b1;
        return !m_busy[k][ra];
    endfunction

    task automatic check_all();
        logic [3:0] bv;
        int         cnt;
        for (int k = 0; k < 3; k++) begin
            bv  = '0;
            cnt = 0;
            for (int r = 0; r < 4; r++) begin
                bv[r] = m_busy[k][r];
                cnt  += int'(m_busy[k][r]);
            end
            chk($sformatf("rd1[%0d]", k), 32'(rd1_o[k]), 32'(exp_rd(k, ra1)));
            chk($sformatf("rd2[%0d]", k), 32'(rd2_o[k]), 32'(exp_rd(k, ra2)));
            chk($sformatf("rv1[%0d]", k), 32'(rv1_o[k]), 32'(exp_rv(k, ra1)));
            chk($sformatf("rv2[%0d]", k), 32'(rv2_o[k]), 32'(exp_rv(k, ra2)));
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(bv));
            chk($sformatf("busy_cnt[%0d]", k), 32'(cnt_o[k]), 32'(cnt));
        end
    endtask

    // Architectural effect of one clock edge under the current inputs.
    function automatic void model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (we && !(zr[k] != 0 && wa == 2'd0)) begin
                m_mem[k][wa]  = wd;
                m_busy[k][wa] = 1'b0;
            end
            if (iss && !(zr[k] != 0 && ia == 2'd0))
                m_busy[k][ia] = 1'b1;
        end
    endfunction

    task automatic cycle(input bit r, input bit w, input logic [1:0] a, input logic [7:0] d,
                         input bit i, input logic [1:0] iad, input logic [1:0] r1, input logic [1:0] r2);
        rst = r; we = w; wa = a; wd = d; iss = i; ia = iad; ra1 = r1; ra2 = r2;
        if (r) model_clear();
        #3;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        // Reset and release
        cycle(1, 0, 0, 8'h00, 0, 0, 0, 1);
        cycle(0, 0, 0, 8'h00, 0, 0, 2, 3);
        // Write R2, issue R1, then asynchronous reset mid-cycle
        cycle(0, 1, 2, 8'hA5, 0, 0, 2, 1);
        cycle(0, 0, 0, 8'h00, 1, 1, 2, 1);
        cycle(0, 0, 0, 8'h00, 0, 0, 2, 1);
        cycle(1, 0, 0, 8'h00, 0, 0, 2, 1);
        cycle(0, 0, 0, 8'h00, 0, 0, 2, 1);
        // Write with same-cycle read, then plain read
        cycle(0, 1, 3, 8'h3C, 0, 0, 3, 0);
        cycle(0, 0, 0, 8'h00, 0, 0, 3, 0);
        // Scoreboard: issue, pending read, write-back, clear
        cycle(0, 0, 0, 8'h00, 1, 2, 0, 2);
        cycle(0, 0, 0, 8'h00, 0, 0, 0, 2);
        cycle(0, 1, 2, 8'h7F, 0, 0, 0, 2);
        cycle(0, 0, 0, 8'h00, 0, 0, 2, 2);
        // Simultaneous issue and write to R1
        cycle(0, 1, 1, 8'h11, 1, 1, 1, 1);
        cycle(0, 0, 0, 8'h00, 0, 0, 1, 3);
        cycle(0, 1, 1, 8'h22, 0, 0, 1, 0);
        // Fill, re-issue, drain
        for (int a = 0; a < 4; a++) cycle(0, 0, 0, 8'h00, 1, 2'(a), 2'(a), 0);
        cycle(0, 0, 0, 8'h00, 1, 2, 2, 0);
        for (int a = 0; a < 4; a++) cycle(0, 1, 2'(a), 8'(8'h40 + a), 0, 0, 2'(a), 2'(3 - a));
        cycle(0, 0, 0, 8'h00, 0, 0, 0, 1);
        // Write and issue to R0
        cycle(0, 1, 0, 8'hFF, 1, 0, 0, 0);
        cycle(0, 0, 0, 8'h00, 0, 0, 0, 1);
        // Write on an edge where reset is held must not land
        cycle(1, 1, 2, 8'h55, 1, 3, 2, 3);
        cycle(0, 0, 0, 8'h00, 0, 0, 2, 3);
        // Randomized traffic with occasional reset
        for (int n = 0; n < 500; n++)
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the 4x8 register file: 2^ADDR_W registers of DATA_W bits each.
- Two asynchronous read ports and one synchronous write port.
- Optional hardwired-zero R0 and optional write-to-read bypass.
- Per-register pending (scoreboard) bit: the issue stage marks destinations busy and write-back clears them. This lets the datapath stall operand fetch until results land.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, address width; DEPTH = 2^ADDR_W registers.
- ZERO_REG, 0: when 1, R0 always reads 0, ignores writes and is never busy.
- BYPASS, 1: when 1, a same-cycle write is forwarded combinationally to matching read ports.

Ports:
- clk  in  1  clock, rising edge active
- rst  in  1  asynchronous active-high reset
- we  in  1  write enable (write-back)
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- iss  in  1  issue strobe: mark register ia pending
- ia  in  ADDR_W  issue (destination) address
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1
- rd2  out  DATA_W  read data, port 2
- rv1  out  1  port-1 operand valid (not pending)
- rv2  out  1  port-2 operand valid (not pending)
- busy  out  DEPTH  pending bit per register
- busy_cnt  out  ADDR_W+1  number of set busy bits

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst=1:
  - all registers = 0, busy = 0, busy_cnt = 0;
  - hence rd1 = rd2 = 0 and rv1 = rv2 = 1.
  - Release is synchronous to the next clk edge.
  - Reset mid-operation discards all pending state; no write occurs on an edge where rst=1.
- Reads: rdN = mem[raN], combinational. Zero latency for stored data.
- Bypass (BYPASS=1): if we=1 and wa==raN (and not (ZERO_REG=1 and wa==0)), then rdN = wd and rvN = 1 in that same cycle. With BYPASS=0, written data is visible the cycle after the edge.
- Valid: rvN = ~busy[raN], or 1 via bypass as above. With ZERO_REG=1 and raN==0, rvN = 1 and rdN = 0 always.
- Write, at posedge with we=1: mem[wa] <= wd and busy[wa] <= 0. Writing a non-busy register is legal: data is stored and busy stays 0.
- Issue, at posedge with iss=1: busy[ia] <= 1. Issue to R0 with ZERO_REG=1 is ignored.
- Same edge, we and iss to the same address: data is stored AND busy stays 1, because the new producer wins. The bypass still forwards wd that cycle with rvN = 1.
- Same edge, we and iss to different addresses: both take effect independently.
- Issue to an already-busy register: busy stays 1 and the count is unchanged.
- busy_cnt: registered, always equals popcount(busy). It updates the cycle after each edge, consistently with busy, including the simultaneous cases. Range is 0..DEPTH and it never wraps.
- ZERO_REG=1: mem[0] may be omitted. busy[0] is constant 0.

Test Plan:
- Reset, defaults: assert rst mid-run after writing R2=0xA5 and issuing R1 -> all rdN=0x00, busy=4'b0000, busy_cnt=0, rv1=rv2=1, immediately and without waiting for a clk edge.
- Write/read: we=1, wa=3, wd=0x3C; ra1=3 in the same cycle -> rd1=0x3C, rv1=1 via bypass. Next cycle with we=0 -> rd1=0x3C. Repeat with BYPASS=0 -> rd1 is old value 0x00 in the write cycle, 0x3C after.
- Scoreboard: iss=1, ia=2; next cycle ra2=2 -> rv2=0, busy=4'b0100, busy_cnt=1. Then we=1, wa=2, wd=0x7F -> rd2=0x7F, rv2=1 that cycle. After the edge: busy=0, busy_cnt=0.
- Simultaneous issue and write to R1 (iss=1, ia=1, we=1, wa=1, wd=0x11) -> mem[1]=0x11, busy[1]=1 after the edge, busy_cnt=1, rv=0 on a following read of R1.
- Fill and drain: issue R0..R3 on successive cycles -> busy_cnt 1,2,3,4. Re-issue R2 -> busy_cnt stays 4. Write back all four -> busy_cnt reaches 0 with no wrap.
- ZERO_REG=1: we=1, wa=0, wd=0xFF and iss=1, ia=0 -> rd1 (ra1=0) = 0x00, rv1=1, busy[0]=0, busy_cnt unchanged.
